// File: rtl/timer_run_ctrl.sv
// Stopwatch run control: conditions buttons and mode switches, sequences the
// BCD counter through load/count/pause/done, and schedules the digit scan.
//
// state   | meaning
// LOAD    | preset being loaded into the counter (one cycle)
// READY   | preset loaded, waiting for start
// RUN     | counting on each prescaled tick
// PAUSE   | counting suspended, sub-tick progress discarded
// DONE    | terminal count reached, only clear or mode change leaves
module timer_run_ctrl #(
   parameter int TICK_DIV  = 1_000_000,
   parameter int SCAN_DIV  = 100_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       btn_stopstart_i,
   input  logic       btn_clear_i,
   input  logic [1:0] modesel_i,
   input  logic       at_max_i,
   input  logic       at_min_i,
   output logic       cnt_load_o,
   output logic [1:0] preset_sel_o,
   output logic       cnt_en_o,
   output logic       cnt_up_o,
   output logic       running_o,
   output logic       done_o,
   output logic [1:0] scan_sel_o,
   output logic [3:0] an_o
);

   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int DW = $clog2(DB_CYCLES + 1);

   typedef enum logic [2:0] {S_LOAD, S_READY, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            cnt_load_q, running_q, done_q;
   logic [1:0]      ss_sync_q, clr_sync_q;
   logic [1:0]      mode_s1_q, mode_s2_q, mode_prev_q;
   logic [1:0]      btn_sync;
   logic [1:0]      deb_q, press_q;
   logic [DW-1:0]   db_cnt_q [2];
   logic [TW-1:0]   tick_cnt_q;
   logic [SW-1:0]   scan_cnt_q;
   logic [1:0]      scan_sel_q;
   logic            start_p, clear_p, mode_chg, terminal, tick;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ss_sync_q   <= '0;
         clr_sync_q  <= '0;
         mode_s1_q   <= '0;
         mode_s2_q   <= '0;
         mode_prev_q <= '0;
      end else begin
         ss_sync_q   <= {ss_sync_q[0], btn_stopstart_i};
         clr_sync_q  <= {clr_sync_q[0], btn_clear_i};
         mode_s1_q   <= modesel_i;
         mode_s2_q   <= mode_s1_q;
         mode_prev_q <= mode_s2_q;
      end
   end

   assign btn_sync = {clr_sync_q[1], ss_sync_q[1]};

   // Index 0 is stop/start, index 1 is clear; a press pulse fires only when
   // the debounced level is accepted as high.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         deb_q   <= '0;
         press_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (btn_sync[i] == deb_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DW'(DB_CYCLES - 1)) begin
               deb_q[i]    <= btn_sync[i];
               press_q[i]  <= btn_sync[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
            end
         end
      end
   end

   assign start_p  = press_q[0];
   assign clear_p  = press_q[1];
   assign mode_chg = (mode_s2_q != mode_prev_q);
   assign cnt_up_o = ~mode_s2_q[1];
   assign terminal = cnt_up_o ? at_max_i : at_min_i;
   assign tick     = (state_q == S_RUN) && (tick_cnt_q == TW'(TICK_DIV - 1));
   assign cnt_en_o = tick & ~terminal & ~mode_chg & ~clear_p & ~start_p;

   always_comb begin
      case (mode_s2_q)
         2'd0:    preset_sel_o = 2'b00;
         2'd2:    preset_sel_o = 2'b10;
         default: preset_sel_o = 2'b01;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:  state_d = S_READY;
         S_READY: if (mode_chg || clear_p) state_d = S_LOAD;
                  else if (start_p)       state_d = S_RUN;
         S_RUN:   if (mode_chg || clear_p) state_d = S_LOAD;
                  else if (start_p)       state_d = S_PAUSE;
                  else if (tick && terminal) state_d = S_DONE;
         S_PAUSE: if (mode_chg || clear_p) state_d = S_LOAD;
                  else if (start_p)       state_d = S_RUN;
         S_DONE:  if (mode_chg || clear_p) state_d = S_LOAD;
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_LOAD;
         cnt_load_q <= 1'b1;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_load_q <= (state_d == S_LOAD);
         running_q  <= (state_d == S_RUN);
         done_q     <= (state_d == S_DONE);
      end
   end

   // Tick phase restarts on every RUN entry so a resume waits a full period.
   always_ff @(posedge clk_i) begin
      if (reset_i || state_q != S_RUN || state_d != S_RUN || tick) tick_cnt_q <= '0;
      else                                                         tick_cnt_q <= tick_cnt_q + TW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         scan_cnt_q <= '0;
         scan_sel_q <= '0;
      end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
         scan_cnt_q <= '0;
         scan_sel_q <= scan_sel_q + 2'd1;
      end else begin
         scan_cnt_q <= scan_cnt_q + SW'(1);
      end
   end

   always_comb begin
      case (scan_sel_q)
         2'd0:    an_o = 4'b1110;
         2'd1:    an_o = 4'b1101;
         2'd2:    an_o = 4'b1011;
         default: an_o = 4'b0111;
      endcase
   end

   assign cnt_load_o = cnt_load_q;
   assign running_o  = running_q;
   assign done_o     = done_q;
   assign scan_sel_o = scan_sel_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Scoreboard bench for timer_run_ctrl: a cycle-level reference model pushes
// expected outputs each cycle, a monitor pops and compares.
module tb_timer_run_ctrl;

   localparam int TICK_DIV  = 5;
   localparam int SCAN_DIV  = 3;
   localparam int DB_CYCLES = 4;

   logic       clk = 1'b0;
   logic       reset, btn_ss, btn_clr, at_max, at_min;
   logic [1:0] modesel;
   logic       cnt_load, cnt_en, cnt_up, running, done;
   logic [1:0] preset_sel, scan_sel;
   logic [3:0] an;

   always #5 clk = ~clk;

   timer_run_ctrl #(
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV),
      .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .btn_stopstart_i(btn_ss),
      .btn_clear_i    (btn_clr),
      .modesel_i      (modesel),
      .at_max_i       (at_max),
      .at_min_i       (at_min),
      .cnt_load_o     (cnt_load),
      .preset_sel_o   (preset_sel),
      .cnt_en_o       (cnt_en),
      .cnt_up_o       (cnt_up),
      .running_o      (running),
      .done_o         (done),
      .scan_sel_o     (scan_sel),
      .an_o           (an)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [12:0] exp_q[$];

   // Reference model: behaviour expressed as delay lines, run lengths and
   // cycle counts since reset / since RUN entry.
   typedef enum {M_LOAD, M_READY, M_RUN, M_PAUSE, M_DONE} mstate_t;
   logic [3:0] an_tbl     [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [1:0] preset_tbl [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

   bit       m_valid = 1'b0;
   mstate_t  m_st = M_LOAD, nx;
   int       m_run_cyc, m_cyc, sel;
   bit       m_pipe_ss[$], m_pipe_clr[$];
   bit [1:0] m_pipe_mode[$];
   bit [1:0] m_mode_prev, mv;
   bit       m_deb[2], m_pulse[2], new_pulse[2];
   int       m_mis[2];
   bit       mchg, term, tk, en, s;

   always @(negedge clk) begin
      if (m_valid) begin
         mv   = m_pipe_mode[0];
         mchg = (mv != m_mode_prev);
         term = mv[1] ? at_min : at_max;
         tk   = (m_st == M_RUN) && (m_run_cyc % TICK_DIV == TICK_DIV - 1);
         en   = tk && !term && !mchg && !m_pulse[0] && !m_pulse[1];
         sel  = (m_cyc / SCAN_DIV) % 4;
         exp_q.push_back({m_st == M_LOAD, preset_tbl[mv], en, ~mv[1],
                          m_st == M_RUN, m_st == M_DONE, 2'(sel), an_tbl[sel]});
      end
      if (reset) begin
         m_st        = M_LOAD;
         m_run_cyc   = 0;
         m_cyc       = 0;
         m_pipe_ss   = '{1'b0, 1'b0};
         m_pipe_clr  = '{1'b0, 1'b0};
         m_pipe_mode = '{2'b00, 2'b00};
         m_mode_prev = 2'b00;
         m_deb       = '{1'b0, 1'b0};
         m_mis       = '{0, 0};
         m_pulse     = '{1'b0, 1'b0};
         m_valid     = 1'b1;
      end else if (m_valid) begin
         nx = m_st;
         if (m_st == M_LOAD)                nx = M_READY;
         else if (mchg || m_pulse[1])       nx = M_LOAD;
         else if (m_pulse[0]) begin
            if (m_st == M_READY || m_st == M_PAUSE) nx = M_RUN;
            else if (m_st == M_RUN)                 nx = M_PAUSE;
         end else if (tk && term)           nx = M_DONE;
         m_run_cyc = (m_st == M_RUN && nx == M_RUN) ? m_run_cyc + 1 : 0;
         m_st = nx;
         // A level is accepted after DB_CYCLES consecutive differing cycles.
         for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? m_pipe_ss[0] : m_pipe_clr[0];
            new_pulse[i] = 1'b0;
            if (s != m_deb[i]) begin
               m_mis[i]++;
               if (m_mis[i] == DB_CYCLES) begin
                  m_deb[i]     = s;
                  m_mis[i]     = 0;
                  new_pulse[i] = s;
               end
            end else begin
               m_mis[i] = 0;
            end
         end
         m_pulse = new_pulse;
         m_pipe_ss.push_back(btn_ss);    void'(m_pipe_ss.pop_front());
         m_pipe_clr.push_back(btn_clr);  void'(m_pipe_clr.pop_front());
         m_pipe_mode.push_back(modesel); void'(m_pipe_mode.pop_front());
         m_mode_prev = mv;
         m_cyc++;
      end
   end

   logic [12:0] e, act;
   always @(negedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         act = {cnt_load, preset_sel, cnt_en, cnt_up, running, done, scan_sel, an};
         n_tests++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL outputs t=%0t {load,psel,en,up,run,done,sel,an} actual=%b required=%b",
                     $time, act, e);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // which: 0 = stop/start, 1 = clear, 2 = both together
   task automatic press(input int which, input int hold);
      if (which != 1) btn_ss = 1'b1;
      if (which != 0) btn_clr = 1'b1;
      step(hold);
      btn_ss  = 1'b0;
      btn_clr = 1'b0;
      step(DB_CYCLES + 4);
   endtask

   int wait_cyc;

   initial begin
      reset = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0;
      modesel = 2'd0; at_max = 1'b0; at_min = 1'b0;
      step(3);
      n_tests++;
      if ({cnt_load, cnt_en, running, done, scan_sel, an} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1110}) begin
         n_fail++;
         $display("FAIL reset state t=%0t {load,en,run,done,sel,an} actual=%b required=%b",
                  $time, {cnt_load, cnt_en, running, done, scan_sel, an},
                  {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1110});
      end
      reset = 1'b0;
      step(5);

      btn_ss = 1'b1;
      wait_cyc = 0;
      while (!running && wait_cyc < 50) begin
         step(1);
         wait_cyc++;
      end
      btn_ss = 1'b0;
      n_tests++;
      if (!running) begin
         n_fail++;
         $display("FAIL wait for RUN after start expired t=%0t after %0d cycles", $time, wait_cyc);
      end
      step(DB_CYCLES + 4);
      step(20);
      for (int off = 0; off < TICK_DIV; off++) begin
         step(off);
         press(0, 6);
         step(3);
         press(0, 6);
         step(7);
      end

      modesel = 2'd2;
      step(6);
      press(0, 6);
      step(7);
      at_min = 1'b1;
      step(8);
      press(0, 6);
      press(1, 6);
      at_min = 1'b0;

      press(0, 3);
      step(4);
      press(0, 6);
      step(4);
      press(2, 6);

      modesel = 2'd1;
      step(6);
      press(0, 6);
      step(3);
      press(0, 6);
      modesel = 2'd3;
      step(6);
      press(0, 6);
      step(6);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(8);

      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: press(0, $urandom_range(1, 8));
            3:       press(1, $urandom_range(1, 8));
            4: begin
               modesel = 2'($urandom_range(0, 3));
               step($urandom_range(1, 4));
            end
            5: begin
               at_max = ($urandom_range(0, 3) == 0);
               at_min = ($urandom_range(0, 3) == 0);
               step($urandom_range(1, 10));
            end
            6: begin
               if ($urandom_range(0, 9) == 0) begin
                  reset = 1'b1;
                  step($urandom_range(1, 3));
                  reset = 1'b0;
               end
               step(1);
            end
            default: step($urandom_range(1, 12));
         endcase
      end

      step(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
